// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared widths and enumerations for the sprite memory arbiter.
//   SPRITE_ADDR_W / SPRITE_ATTR_W : sprite index and attribute widths; they
//                                   concatenate into the RAM address.
//   SPRITE_DATA_W                 : RAM data width.
//   cpu_state_t                   : CPU read-sequencing FSM states.
//   owner_t                       : who owns the read whose data returns next.
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int SPRITE_ADDR_W = 8;
    localparam int SPRITE_ATTR_W = 4;
    localparam int SPRITE_DATA_W = 8;
    localparam int SPRITE_MEM_AW = SPRITE_ADDR_W + SPRITE_ATTR_W;

    typedef enum logic {
        C_IDLE   = 1'b0,
        C_RDWAIT = 1'b1
    } cpu_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        RND  = 2'd2
    } owner_t;

    // RAM address layout: sprite index in the high bits, attribute below it.
    function automatic logic [SPRITE_MEM_AW-1:0] sprite_mem_index(
        input logic [SPRITE_ADDR_W-1:0] addr,
        input logic [SPRITE_ATTR_W-1:0] attr
    );
        return {addr, attr};
    endfunction

endpackage

// File: rtl/sprite_arb_prio.sv
// -----------------------------------------------------------------------------
// sprite_arb_prio
// Purely combinational grant decision between the CPU and the renderer.
// The renderer normally wins; a CPU that has been denied STARVE_LIMIT
// consecutive eligible cycles is forced through. Also computes the next
// starvation count; the register itself lives in the parent.
// Ports:
//   enable      : grants allowed (low while the arbiter is in reset)
//   cpu_req     : CPU command present
//   cpu_idle    : CPU FSM is idle (CPU may be granted)
//   rnd_req     : renderer read request
//   starve_cnt  : current consecutive-denial count
//   cpu_gnt     : CPU granted this cycle
//   rnd_gnt     : renderer granted this cycle
//   starve_next : starvation count for the next cycle
// -----------------------------------------------------------------------------
module sprite_arb_prio #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             enable,
    input  logic             cpu_req,
    input  logic             cpu_idle,
    input  logic             rnd_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             cpu_gnt,
    output logic             rnd_gnt,
    output logic [CNT_W-1:0] starve_next
);

    logic cpu_elig;
    logic cpu_forced;

    always_comb begin
        cpu_elig   = cpu_req && cpu_idle;
        cpu_forced = cpu_elig && (starve_cnt >= CNT_W'(STARVE_LIMIT));

        rnd_gnt = enable && rnd_req && !cpu_forced;
        cpu_gnt = enable && cpu_elig && (cpu_forced || !rnd_req);

        // A dropped request or a grant clears the count; a denied eligible
        // cycle bumps it (saturating). While the CPU waits for read data it
        // is not eligible, so the count simply holds.
        if (!cpu_req || cpu_gnt) begin
            starve_next = '0;
        end else if (cpu_elig && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
            starve_next = starve_cnt + CNT_W'(1);
        end else begin
            starve_next = starve_cnt;
        end
    end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_mem_arbiter
// Shares one single-port synchronous sprite RAM between the CPU EX stage
// (reads and writes, stalls the pipeline while waiting) and the renderer
// (reads only, may issue every cycle). One access per cycle at most.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cpu_req/we/addr/attr/wdata      : CPU command, held while cpu_stall=1
//   cpu_stall                       : stall the CPU pipeline
//   cpu_rdata, cpu_rvalid           : CPU read return (holds last value)
//   rnd_req/addr/attr               : renderer read request
//   rnd_gnt                         : renderer grant pulse
//   rnd_rdata, rnd_rvalid           : renderer read return, one cycle after
//                                     grant (holds last value)
//   mem_addr/re/we/wdata, mem_rdata : RAM port, read data one cycle after re
// STARVE_LIMIT must be at least 1.
// -----------------------------------------------------------------------------
module sprite_mem_arbiter
    import sprite_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [SPRITE_ADDR_W-1:0] cpu_addr,
    input  logic [SPRITE_ATTR_W-1:0] cpu_attr,
    input  logic [SPRITE_DATA_W-1:0] cpu_wdata,
    output logic                     cpu_stall,
    output logic [SPRITE_DATA_W-1:0] cpu_rdata,
    output logic                     cpu_rvalid,
    input  logic                     rnd_req,
    input  logic [SPRITE_ADDR_W-1:0] rnd_addr,
    input  logic [SPRITE_ATTR_W-1:0] rnd_attr,
    output logic                     rnd_gnt,
    output logic [SPRITE_DATA_W-1:0] rnd_rdata,
    output logic                     rnd_rvalid,
    output logic [SPRITE_MEM_AW-1:0] mem_addr,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [SPRITE_DATA_W-1:0] mem_wdata,
    input  logic [SPRITE_DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    cpu_state_t               cpu_state_reg, cpu_state_next;
    owner_t                   owner_reg, owner_next;
    logic [CNT_W-1:0]         starve_cnt_reg, starve_cnt_next;
    logic [SPRITE_DATA_W-1:0] cpu_rdata_reg, rnd_rdata_reg;
    logic                     cpu_gnt;

    // Grants are suppressed combinationally while rst_n is low so that no
    // memory access or grant pulse leaks out during reset.
    sprite_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_prio (
        .enable      (rst_n),
        .cpu_req     (cpu_req),
        .cpu_idle    (cpu_state_reg == C_IDLE),
        .rnd_req     (rnd_req),
        .starve_cnt  (starve_cnt_reg),
        .cpu_gnt     (cpu_gnt),
        .rnd_gnt     (rnd_gnt),
        .starve_next (starve_cnt_next)
    );

    // Memory port mux, FSM next state and return routing.
    always_comb begin
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = sprite_mem_index(cpu_addr, cpu_attr);
        mem_wdata      = cpu_wdata;
        owner_next     = NONE;
        cpu_state_next = C_IDLE;

        if (rnd_gnt) begin
            mem_re     = 1'b1;
            mem_addr   = sprite_mem_index(rnd_addr, rnd_attr);
            owner_next = RND;
        end else if (cpu_gnt) begin
            mem_we = cpu_we;
            mem_re = !cpu_we;
            if (!cpu_we) begin
                owner_next     = CPU;
                cpu_state_next = C_RDWAIT;
            end
        end

        // Returns follow the registered owner tag, not the live requests:
        // the renderer may already be issuing its next read in this cycle.
        cpu_rvalid = (owner_reg == CPU);
        rnd_rvalid = (owner_reg == RND);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_reg;
        rnd_rdata  = rnd_rvalid ? mem_rdata : rnd_rdata_reg;

        // A write retires in its grant cycle; a read retires when its data
        // comes back.
        cpu_stall = cpu_req && !((cpu_gnt && cpu_we) || (cpu_state_reg == C_RDWAIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_state_reg  <= C_IDLE;
            owner_reg      <= NONE;
            starve_cnt_reg <= '0;
            cpu_rdata_reg  <= '0;
            rnd_rdata_reg  <= '0;
        end else begin
            cpu_state_reg  <= cpu_state_next;
            owner_reg      <= owner_next;
            starve_cnt_reg <= starve_cnt_next;
            if (cpu_rvalid) begin
                cpu_rdata_reg <= mem_rdata;
            end
            if (rnd_rvalid) begin
                rnd_rdata_reg <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_mem_arbiter
// Drives CPU and renderer traffic into sprite_mem_arbiter with a behavioural
// sprite RAM attached. Expected read data is pushed into per-requester queues
// when a grant is observed and popped when the matching rvalid appears.
// -----------------------------------------------------------------------------
module tb_sprite_mem_arbiter;
    import sprite_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [3:0]  cpu_attr;
    logic [7:0]  cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        rnd_req;
    logic [7:0]  rnd_addr;
    logic [3:0]  rnd_attr;
    logic        rnd_gnt, rnd_rvalid;
    logic [7:0]  rnd_rdata;
    logic [11:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram     [0:4095];
    logic [7:0] ref_mem [0:4095];
    logic       ram_load;
    logic [7:0] cpu_q[$];
    logic [7:0] rnd_q[$];
    logic [7:0] cpu_e, rnd_e;

    always #5 clk = ~clk;

    sprite_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_attr   (cpu_attr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .rnd_req    (rnd_req),
        .rnd_addr   (rnd_addr),
        .rnd_attr   (rnd_attr),
        .rnd_gnt    (rnd_gnt),
        .rnd_rdata  (rnd_rdata),
        .rnd_rvalid (rnd_rvalid),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural single-port synchronous RAM.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 7 + 3);
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    // Scoreboard: every rvalid must match the oldest expected value.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            checks++;
            if (cpu_q.size() == 0) begin
                failures++;
                $display("FAIL cpu_return_unexpected got=%h want=no_return", cpu_rdata);
            end else begin
                cpu_e = cpu_q.pop_front();
                if (cpu_rdata !== cpu_e) begin
                    failures++;
                    $display("FAIL cpu_return_data got=%h want=%h", cpu_rdata, cpu_e);
                end else $display("cpu return data=%h", cpu_rdata);
            end
        end
        if (rnd_rvalid) begin
            checks++;
            if (rnd_q.size() == 0) begin
                failures++;
                $display("FAIL rnd_return_unexpected got=%h want=no_return", rnd_rdata);
            end else begin
                rnd_e = rnd_q.pop_front();
                if (rnd_rdata !== rnd_e) begin
                    failures++;
                    $display("FAIL rnd_return_data got=%h want=%h", rnd_rdata, rnd_e);
                end else $display("rnd return data=%h", rnd_rdata);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        rnd_req = 1'b1;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL reset_cpu_stall got=%b want=1", cpu_stall); end
        checks++; if (rnd_gnt !== 1'b0) begin failures++; $display("FAIL reset_rnd_gnt got=%b want=0", rnd_gnt); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b%b want=00", mem_re, mem_we); end
        checks++; if (cpu_rvalid !== 1'b0 || rnd_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b want=00", cpu_rvalid, rnd_rvalid); end
        checks++; if (cpu_rdata !== 8'h00 || rnd_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h/%h want=00/00", cpu_rdata, rnd_rdata); end
        $display("reset: stall=%b gnt=%b re=%b we=%b", cpu_stall, rnd_gnt, mem_re, mem_we);
        next_cycle();
        rst_n   = 1'b1;
        cpu_req = 1'b0;
        rnd_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL idle_after_reset got=stall%b re%b want=0/0", cpu_stall, mem_re); end
        next_cycle();
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_attr = 4'h3; cpu_wdata = 8'hA5;
        rnd_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin failures++; $display("FAIL wr_mem_en got=re%b we%b want=re0 we1", mem_re, mem_we); end
        checks++; if (mem_addr !== 12'h123) begin failures++; $display("FAIL wr_mem_addr got=%h want=123", mem_addr); end
        checks++; if (mem_wdata !== 8'hA5) begin failures++; $display("FAIL wr_mem_wdata got=%h want=a5", mem_wdata); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL wr_cpu_stall got=%b want=0", cpu_stall); end
        $display("cpu write addr=%h data=%h stall=%b", mem_addr, mem_wdata, cpu_stall);
        ref_mem[12'h123] = 8'hA5;
        next_cycle();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12; cpu_attr = 4'h3;
        @(negedge clk);
        checks++; if (mem_re !== 1'b1 || mem_addr !== 12'h123) begin failures++; $display("FAIL rd_issue got=re%b addr%h want=re1 addr123", mem_re, mem_addr); end
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rd_grant_stall got=%b want=1", cpu_stall); end
        cpu_q.push_back(ref_mem[12'h123]);
        $display("cpu read issue addr=%h stall=%b", mem_addr, cpu_stall);
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_stall !== 1'b0) begin failures++; $display("FAIL rd_wait got=rvalid%b stall%b want=1/0", cpu_rvalid, cpu_stall); end
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL rd_wait_no_reissue got=%b want=0", mem_re); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'hA5) begin failures++; $display("FAIL rd_hold got=rvalid%b data%h want=0/a5", cpu_rvalid, cpu_rdata); end
        next_cycle();
    endtask

    // Renderer hammers every cycle while the CPU waits for a read: four
    // renderer grants, then the forced CPU grant, then the renderer again.
    task automatic test_starvation();
        logic        exp_rnd;
        logic [11:0] exp_addr;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40; cpu_attr = 4'h1;
        rnd_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rnd_addr = 8'(8'h80 + c); rnd_attr = 4'h2;
            @(negedge clk);
            exp_rnd  = (c != LIMIT);
            exp_addr = exp_rnd ? {rnd_addr, rnd_attr} : 12'h401;
            checks++; if (rnd_gnt !== exp_rnd) begin failures++; $display("FAIL starve_gnt_c%0d got=%b want=%b", c, rnd_gnt, exp_rnd); end
            checks++; if (cpu_stall !== (c != LIMIT + 1)) begin failures++; $display("FAIL starve_stall_c%0d got=%b want=%b", c, cpu_stall, c != LIMIT + 1); end
            checks++; if (mem_re !== 1'b1 || mem_addr !== exp_addr) begin failures++; $display("FAIL starve_mem_c%0d got=re%b addr%h want=re1 addr%h", c, mem_re, mem_addr, exp_addr); end
            if (exp_rnd) rnd_q.push_back(ref_mem[exp_addr]);
            else         cpu_q.push_back(ref_mem[exp_addr]);
            $display("starve cycle %0d rnd_gnt=%b addr=%h stall=%b", c, rnd_gnt, mem_addr, cpu_stall);
            next_cycle();
        end
        cpu_req = 1'b0; rnd_req = 1'b0;
        @(negedge clk);
        next_cycle();
    endtask

    // Renderer reads 0x000..0x002 back to back, starting while the CPU read
    // is returning.
    task automatic test_back_to_back();
        logic [11:0] a;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h7F; cpu_attr = 4'hF;
        rnd_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_re !== 1'b1 || mem_addr !== 12'h7FF || cpu_stall !== 1'b1) begin failures++; $display("FAIL b2b_cpu_issue got=re%b addr%h stall%b want=1/7ff/1", mem_re, mem_addr, cpu_stall); end
        cpu_q.push_back(ref_mem[12'h7FF]);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            cpu_req  = (k == 1);
            rnd_req  = (k <= 3);
            rnd_addr = 8'h00;
            rnd_attr = 4'(k - 1);
            @(negedge clk);
            checks++; if (rnd_gnt !== (k <= 3)) begin failures++; $display("FAIL b2b_gnt_k%0d got=%b want=%b", k, rnd_gnt, k <= 3); end
            checks++; if (rnd_rvalid !== (k >= 2)) begin failures++; $display("FAIL b2b_rnd_rvalid_k%0d got=%b want=%b", k, rnd_rvalid, k >= 2); end
            checks++; if (cpu_rvalid !== (k == 1)) begin failures++; $display("FAIL b2b_cpu_rvalid_k%0d got=%b want=%b", k, cpu_rvalid, k == 1); end
            if (k <= 3) begin
                a = {8'h00, 4'(k - 1)};
                checks++; if (mem_addr !== a) begin failures++; $display("FAIL b2b_addr_k%0d got=%h want=%h", k, mem_addr, a); end
                rnd_q.push_back(ref_mem[a]);
            end
            $display("b2b cycle %0d rnd_gnt=%b rnd_rvalid=%b cpu_rvalid=%b", k, rnd_gnt, rnd_rvalid, cpu_rvalid);
            next_cycle();
        end
        cpu_req = 1'b0; rnd_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12; cpu_attr = 4'h3;
        rnd_req = 1'b0;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || rnd_gnt !== 1'b0) begin failures++; $display("FAIL rstmid_quiet got=re%b we%b gnt%b want=000", mem_re, mem_we, rnd_gnt); end
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rstmid_stall got=%b want=1", cpu_stall); end
        checks++; if (dut.starve_cnt_reg !== '0) begin failures++; $display("FAIL rstmid_starve got=%0d want=0", dut.starve_cnt_reg); end
        checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL rstmid_rdata got=%h want=00", cpu_rdata); end
        next_cycle();
        rst_n = 1'b1; cpu_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_no_return_%0d got=%b want=0", k, cpu_rvalid); end
            next_cycle();
        end
        cpu_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_re !== 1'b1 || cpu_stall !== 1'b1) begin failures++; $display("FAIL rstmid_reissue got=re%b stall%b want=1/1", mem_re, cpu_stall); end
        cpu_q.push_back(ref_mem[12'h123]);
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_stall !== 1'b0) begin failures++; $display("FAIL rstmid_complete got=rvalid%b stall%b want=1/0", cpu_rvalid, cpu_stall); end
        $display("reset mid read: reissued read returned rvalid=%b data=%h", cpu_rvalid, cpu_rdata);
        next_cycle();
        cpu_req = 1'b0;
    endtask

    // Three denied cycles, then the CPU drops its request: the count must
    // restart so the next request waits four full denials again.
    task automatic test_starve_clear();
        logic [11:0] a;
        cpu_we = 1'b0; cpu_addr = 8'h55; cpu_attr = 4'h5;
        rnd_req = 1'b1; rnd_attr = 4'h7;
        for (int c = 0; c < 4; c++) begin
            cpu_req  = (c < 3);
            rnd_addr = 8'(8'hC0 + c);
            @(negedge clk);
            checks++; if (rnd_gnt !== 1'b1) begin failures++; $display("FAIL clr_pre_gnt_c%0d got=%b want=1", c, rnd_gnt); end
            rnd_q.push_back(ref_mem[{rnd_addr, rnd_attr}]);
            next_cycle();
        end
        cpu_req = 1'b1;
        for (int d = 0; d < 6; d++) begin
            rnd_addr = 8'(8'hD0 + d);
            @(negedge clk);
            if (d == 0) begin
                checks++; if (dut.starve_cnt_reg !== '0) begin failures++; $display("FAIL clr_starve_cleared got=%0d want=0", dut.starve_cnt_reg); end
            end
            checks++; if (rnd_gnt !== (d != LIMIT)) begin failures++; $display("FAIL clr_gnt_d%0d got=%b want=%b", d, rnd_gnt, d != LIMIT); end
            checks++; if (cpu_stall !== (d != LIMIT + 1)) begin failures++; $display("FAIL clr_stall_d%0d got=%b want=%b", d, cpu_stall, d != LIMIT + 1); end
            a = (d != LIMIT) ? {rnd_addr, rnd_attr} : 12'h555;
            if (d != LIMIT) rnd_q.push_back(ref_mem[a]);
            else            cpu_q.push_back(ref_mem[a]);
            $display("starve clear cycle %0d rnd_gnt=%b stall=%b", d, rnd_gnt, cpu_stall);
            next_cycle();
        end
        cpu_req = 1'b0; rnd_req = 1'b0;
        @(negedge clk);
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0; ram_load = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_attr = 4'h0; cpu_wdata = 8'h00;
        rnd_req = 1'b0; rnd_addr = 8'h00; rnd_attr = 4'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 7 + 3);
        next_cycle();
        ram_load = 1'b0;

        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();
        test_starve_clear();

        repeat (2) next_cycle();
        checks++; if (cpu_q.size() != 0) begin failures++; $display("FAIL cpu_queue_drained got=%0d want=0", cpu_q.size()); end
        checks++; if (rnd_q.size() != 0) begin failures++; $display("FAIL rnd_queue_drained got=%0d want=0", rnd_q.size()); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
